reg_bank_param: RTL and testbench
=================================

# reg_bank_param

Parametrised successor to the fixed 32×32 register block. It provides a bank of NUM_REGS registers of DATA_W bits, with per-register read-write or read-only selection and per-register reset defaults, both set by parameters. It also adds write strobes, a read-valid handshake, an illegal-access counter and an optional shadow/commit scheme. It sits between the Master-FPGA serial link decoder and the acquisition/DDR3 control logic, on the 125 MHz interconnect clock.

## Interface
- NUM_REGS, 32: number of registers (2..256).
- DATA_W, 32: register and bus width (8..32).
- RO_MASK, {NUM_REGS{1'b0}}: bit i = 1 makes register i read-only.
- RESET_VALS, all zero: flat NUM_REGS*DATA_W vector; slice i is register i's reset value.
- clk  in  1  125 MHz interconnect clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  DATA_W  write data / register number from Master FPGA.
- reg_num_le  in  1  latch rx_data as selected register number.
- wr_en  in  1  write rx_data to selected register.
- rd_en  in  1  read selected register.
- tx_data  out  DATA_W  read-back data.
- tx_valid  out  1  one-cycle pulse, tx_data updated.
- illegal_reg_num  out  1  latched number ≥ NUM_REGS.
- illegal_access  out  1  one-cycle pulse on a rejected access.
- err_cnt  out  16  saturating count of rejected accesses.
- err_cnt_clr  in  1  synchronous clear of err_cnt.
- reg_out  out  NUM_REGS*DATA_W  active register values to fabric.
- ro_in  in  NUM_REGS*DATA_W  values returned for read-only registers.
- wr_strobe  out  NUM_REGS  per-register one-cycle update pulse.
- commit  in  1  apply shadow contents (only with REG_SHADOW_COMMIT_EN).
- shadow_pending  out  1  at least one shadow register not yet committed.

## Operation
- reg_num holds a full DATA_W bits. illegal_reg_num = (reg_num ≥ NUM_REGS), decoded combinationally from reg_num.
- A legal write needs wr_en = 1, reg_num < NUM_REGS and RO_MASK[reg_num] = 0. It stores rx_data into register reg_num.
- A rejected write (out of range or read-only) changes no register. It pulses illegal_access and increments err_cnt.
- A read with rd_en = 1 loads tx_data and pulses tx_valid:
  - RW register: its stored value (the shadow value when shadowing is compiled in).
  - RO register: ro_in slice.
  - Out of range: tx_data = 0, illegal_access pulses, err_cnt increments.
- A rejected read plus a rejected write in the same cycle counts as one error.
- tx_data holds its value between reads.
- err_cnt saturates at 16'hFFFF. err_cnt_clr has priority over any increment in the same cycle.
- Simultaneous reg_num_le and wr_en/rd_en: the access uses the old reg_num.
- Simultaneous rd_en and wr_en to the same register: tx_data returns the pre-write value.

## Timing
- Reset (asynchronous, reset = 0):
  - registers and shadows = RESET_VALS
  - reg_num = 0
  - tx_data = 0
  - tx_valid, illegal_access, wr_strobe, err_cnt, dirty bits, shadow_pending = 0
- reg_num_le in cycle N: new reg_num is in effect from cycle N+1.
- Write in cycle N (no shadow): reg_out is updated in N+1, and wr_strobe[i] is high in N+1 only.
- Read in cycle N: tx_data and tx_valid appear in N+1. Back-to-back reads give back-to-back tx_valid pulses.
- illegal_access pulses in N+1. err_cnt is updated in N+1.

## Configuration
- REG_SHADOW_COMMIT_EN defined:
  - A write updates shadow[i] and sets dirty[i]. reg_out is unchanged.
  - commit in cycle N copies every dirty shadow to active. In N+1, reg_out is updated and wr_strobe pulses for exactly the dirty registers; those dirty bits clear.
  - shadow_pending = |dirty.
  - Write and commit in the same cycle: commit uses the pre-write shadow contents. The new write stays dirty.
- REG_SHADOW_COMMIT_EN undefined:
  - No shadow storage; writes go straight to active registers.
  - commit is ignored and shadow_pending is tied 0.

## Structure
- Package reg_bank_pkg contains:
  - a clog2-style address-width function
  - default NUM_REGS and DATA_W constants
  - the err_cnt width constant (16)
  - the err_cnt saturation value
- Sub-module reg_bank_slot: one active register, its optional shadow and dirty bit, and wr_strobe generation. It is instantiated NUM_REGS times by a generate loop.

## Test plan
- Reset with RESET_VALS slice 2 = 70000 -> reg_out slice 2 = 70000; tx_data = 0; err_cnt = 0.
- Latch 5, write 0xDEADBEEF, then read -> reg_out[5] and wr_strobe[5] in N+1; tx_data = 0xDEADBEEF with tx_valid one cycle after the read.
- RO_MASK bit 7 set, ro_in slice 7 = 0x1234: write 0x55 then read reg 7 -> register unchanged, illegal_access pulses once, err_cnt = 1, tx_data = 0x1234.
- Latch 40 with NUM_REGS = 32 -> illegal_reg_num = 1; read gives tx_data = 0 and err_cnt + 1. With err_cnt preloaded to 0xFFFF, it stays at 0xFFFF.
- Shadow build: write reg 3 = 9 -> reg_out[3] unchanged and shadow_pending = 1. commit -> reg_out[3] = 9, wr_strobe[3] only, shadow_pending = 0.
- reset = 0 asserted mid-write, and during commit -> all outputs return to their reset values immediately, asynchronously.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the parametrised register bank.
package reg_bank_pkg;

  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned ERR_CNT_W    = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

  // Bits needed to index n registers (minimum 1).
  function automatic int unsigned addr_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_bank_slot.sv
// One register slot: active value, optional shadow + dirty bit, update strobe.
// Optional feature: REG_SHADOW_COMMIT_EN adds the shadow/commit path.
module reg_bank_slot #(
  parameter int unsigned DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              commit_i,
  output logic [DATA_W-1:0] active_o,
  output logic [DATA_W-1:0] rd_val_o,
  output logic              dirty_o,
  output logic              strobe_o
);

  logic [DATA_W-1:0] act_q, act_d;
  logic              strobe_q, strobe_d;

`ifdef REG_SHADOW_COMMIT_EN
  logic [DATA_W-1:0] shd_q, shd_d;
  logic              dirty_q, dirty_d;

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q    <= RST_VAL;
      shd_q    <= RST_VAL;
      dirty_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      act_q    <= act_d;
      shd_q    <= shd_d;
      dirty_q  <= dirty_d;
      strobe_q <= strobe_d;
    end
  end

  // Commit moves the pre-write shadow; a same-cycle write stays dirty.
  always_comb begin
    act_d    = act_q;
    shd_d    = shd_q;
    dirty_d  = dirty_q;
    strobe_d = 1'b0;
    if (commit_i && dirty_q) begin
      act_d    = shd_q;
      dirty_d  = 1'b0;
      strobe_d = 1'b1;
    end
    if (wr_i) begin
      shd_d   = wdata_i;
      dirty_d = 1'b1;
    end
  end

  assign rd_val_o = shd_q;
  assign dirty_o  = dirty_q;
`else
  logic unused_commit;
  assign unused_commit = commit_i;

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q    <= RST_VAL;
      strobe_q <= 1'b0;
    end else begin
      act_q    <= act_d;
      strobe_q <= strobe_d;
    end
  end

  // Writes land directly in the active register.
  always_comb begin
    act_d    = act_q;
    strobe_d = wr_i;
    if (wr_i) begin
      act_d = wdata_i;
    end
  end

  assign rd_val_o = act_q;
  assign dirty_o  = 1'b0;
`endif

  assign active_o = act_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank with RO/RW selection, read handshake,
// rejected-access counter and optional shadow/commit (REG_SHADOW_COMMIT_EN).
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter logic [NUM_REGS-1:0]        RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       reg_num_le,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  output logic                       illegal_reg_num,
  output logic                       illegal_access,
  output logic [ERR_CNT_W-1:0]       err_cnt,
  input  logic                       err_cnt_clr,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] ro_in,
  output logic [NUM_REGS-1:0]        wr_strobe,
  input  logic                       commit,
  output logic                       shadow_pending
);

  localparam int unsigned AW = addr_w(NUM_REGS);

  logic [DATA_W-1:0]    reg_num_q, reg_num_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 illegal_access_q, illegal_access_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [AW-1:0]        idx_c;
  logic                 in_range_c;
  logic                 ro_sel_c;
  logic                 wr_legal_c;
  logic                 err_evt_c;
  logic [DATA_W-1:0]    rd_data_c;

  logic [DATA_W-1:0]    rd_vals [NUM_REGS];
  logic [DATA_W-1:0]    ro_vals [NUM_REGS];
  logic [NUM_REGS-1:0]  dirty;

  // Address decode and access legality.
  assign idx_c      = reg_num_q[AW-1:0];
  assign in_range_c = (33'(reg_num_q) < 33'(NUM_REGS));
  assign ro_sel_c   = RO_MASK[idx_c];
  assign wr_legal_c = wr_en && in_range_c && !ro_sel_c;
  assign err_evt_c  = (wr_en && !(in_range_c && !ro_sel_c)) || (rd_en && !in_range_c);

  // Register slots, one per address.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
    reg_bank_slot #(
      .DATA_W  (DATA_W),
      .RST_VAL (RESET_VALS[g*DATA_W +: DATA_W])
    ) u_slot (
      .clk      (clk),
      .rst_n    (reset),
      .wr_i     (wr_legal_c && (idx_c == AW'(g))),
      .wdata_i  (rx_data),
      .commit_i (commit),
      .active_o (reg_out[g*DATA_W +: DATA_W]),
      .rd_val_o (rd_vals[g]),
      .dirty_o  (dirty[g]),
      .strobe_o (wr_strobe[g])
    );
    assign ro_vals[g] = ro_in[g*DATA_W +: DATA_W];
  end

  // Read data source: stored/shadow value, fabric value for RO, zero out of range.
  always_comb begin
    rd_data_c = '0;
    if (in_range_c) begin
      rd_data_c = ro_sel_c ? ro_vals[idx_c] : rd_vals[idx_c];
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_num_q        <= '0;
      tx_data_q        <= '0;
      tx_valid_q       <= 1'b0;
      illegal_access_q <= 1'b0;
      err_cnt_q        <= '0;
    end else begin
      reg_num_q        <= reg_num_d;
      tx_data_q        <= tx_data_d;
      tx_valid_q       <= tx_valid_d;
      illegal_access_q <= illegal_access_d;
      err_cnt_q        <= err_cnt_d;
    end
  end

  // Next state: accesses use the pre-latch reg_num; clear beats increment.
  always_comb begin
    reg_num_d        = reg_num_q;
    tx_data_d        = tx_data_q;
    tx_valid_d       = rd_en;
    illegal_access_d = err_evt_c;
    err_cnt_d        = err_cnt_q;
    if (reg_num_le) begin
      reg_num_d = rx_data;
    end
    if (rd_en) begin
      tx_data_d = rd_data_c;
    end
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (err_evt_c && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign tx_data         = tx_data_q;
  assign tx_valid        = tx_valid_q;
  assign illegal_access  = illegal_access_q;
  assign err_cnt         = err_cnt_q;
  assign illegal_reg_num = !in_range_c;
  assign shadow_pending  = |dirty;

endmodule

// File: tb/tb_reg_bank_param.sv
// Bench for reg_bank_param: vector table plus hand sequences, read scoreboard.
module tb_reg_bank_param;

  localparam int unsigned NR = 32;
  localparam int unsigned DW = 32;
  localparam logic [NR-1:0]    ROM = 32'h0000_0080;
  localparam logic [NR*DW-1:0] RV  = (1024'(70000) << 64);
`ifdef REG_SHADOW_COMMIT_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [DW-1:0]    rx_data;
  logic             reg_num_le, wr_en, rd_en, err_cnt_clr, commit;
  logic [DW-1:0]    tx_data;
  logic             tx_valid, illegal_reg_num, illegal_access, shadow_pending;
  logic [15:0]      err_cnt;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] ro_in;
  logic [NR-1:0]    wr_strobe;

  reg_bank_param #(
    .NUM_REGS (NR), .DATA_W (DW), .RO_MASK (ROM), .RESET_VALS (RV)
  ) dut (
    .clk (clk), .reset (reset), .rx_data (rx_data), .reg_num_le (reg_num_le),
    .wr_en (wr_en), .rd_en (rd_en), .tx_data (tx_data), .tx_valid (tx_valid),
    .illegal_reg_num (illegal_reg_num), .illegal_access (illegal_access),
    .err_cnt (err_cnt), .err_cnt_clr (err_cnt_clr), .reg_out (reg_out),
    .ro_in (ro_in), .wr_strobe (wr_strobe), .commit (commit),
    .shadow_pending (shadow_pending)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  typedef enum logic [2:0] {OP_LATCH, OP_WR, OP_RD, OP_RW, OP_LW, OP_CLRWR} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] data;
    logic [31:0] exp_tx;
    int          exp_wr;
    logic        exp_ia;
    logic [15:0] exp_err;
    logic        exp_ill;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] m_act [NR];
  logic [31:0] m_shd [NR];
  logic [31:0] m_pend;
  vec_t        vt [24];
  vec_t        v;
  logic [31:0] s1, s2;

  function automatic vec_t mk(input op_e op, input logic [31:0] d, input logic [31:0] tx,
                              input int wr, input logic ia, input logic [15:0] err,
                              input logic ill);
    vec_t r;
    r.op = op; r.data = d; r.exp_tx = tx; r.exp_wr = wr;
    r.exp_ia = ia; r.exp_err = err; r.exp_ill = ill;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string nm);
    logic ok;
    int   bi;
    ok = 1'b1;
    bi = 0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (reg_out[i*DW +: DW] !== m_act[i]) begin
        ok = 1'b0;
        bi = i;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: reg_out[%0d] got %0h, required %0h", nm, bi, reg_out[bi*DW +: DW], m_act[bi]);
    end
  endtask

  task automatic m_init();
    for (int i = 0; i < NR; i++) begin
      m_act[i] = RV[i*DW +: DW];
      m_shd[i] = RV[i*DW +: DW];
    end
    m_pend = '0;
  endtask

  task automatic m_write(input int i, input logic [31:0] d, output logic [31:0] stb);
    m_shd[i] = d;
    stb = '0;
    if (SHADOW) m_pend[i] = 1'b1;
    else begin
      m_act[i] = d;
      stb[i]   = 1'b1;
    end
  endtask

  task automatic m_commit(output logic [31:0] stb);
    stb = SHADOW ? m_pend : 32'd0;
    for (int i = 0; i < NR; i++) if (stb[i]) m_act[i] = m_shd[i];
    m_pend = '0;
  endtask

  task automatic drive(input logic le, input logic we, input logic re, input logic clr,
                       input logic cm, input logic [31:0] d);
    reg_num_le = le; wr_en = we; rd_en = re; err_cnt_clr = clr; commit = cm; rx_data = d;
  endtask

  // One clock; read results are popped from the scoreboard as they appear.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("tx_valid", 64'(tx_valid), 64'(1'b1));
      chk("tx_data", 64'(tx_data), 64'(e));
    end else begin
      chk("tx_valid_idle", 64'(tx_valid), 64'(1'b0));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tx_data"}, 64'(tx_data), 64'(0));
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'(0));
    chk({tag, "_illegal_access"}, 64'(illegal_access), 64'(0));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
    chk({tag, "_wr_strobe"}, 64'(wr_strobe), 64'(0));
    chk({tag, "_shadow_pending"}, 64'(shadow_pending), 64'(0));
    chk({tag, "_illegal_reg_num"}, 64'(illegal_reg_num), 64'(0));
    chk({tag, "_reg2"}, 64'(reg_out[2*DW +: DW]), 64'(70000));
    chk_regs({tag, "_reg_out"});
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < NR; i++)
      ro_in[i*DW +: DW] = (i == 7) ? 32'h1234 : (32'hA000_0000 | 32'(i));
    m_init();

    vt[0]  = mk(OP_LATCH, 32'd5,         32'd0,         -1, 1'b0, 16'd0, 1'b0);
    vt[1]  = mk(OP_WR,    32'hDEADBEEF,  32'd0,          5, 1'b0, 16'd0, 1'b0);
    vt[2]  = mk(OP_RD,    32'd0,         32'hDEADBEEF,  -1, 1'b0, 16'd0, 1'b0);
    vt[3]  = mk(OP_LATCH, 32'd7,         32'd0,         -1, 1'b0, 16'd0, 1'b0);
    vt[4]  = mk(OP_WR,    32'h55,        32'd0,         -1, 1'b1, 16'd1, 1'b0);
    vt[5]  = mk(OP_RD,    32'd0,         32'h1234,      -1, 1'b0, 16'd1, 1'b0);
    vt[6]  = mk(OP_LATCH, 32'd2,         32'd0,         -1, 1'b0, 16'd1, 1'b0);
    vt[7]  = mk(OP_RD,    32'd0,         32'd70000,     -1, 1'b0, 16'd1, 1'b0);
    vt[8]  = mk(OP_LATCH, 32'd40,        32'd0,         -1, 1'b0, 16'd1, 1'b1);
    vt[9]  = mk(OP_RD,    32'd0,         32'd0,         -1, 1'b1, 16'd2, 1'b1);
    vt[10] = mk(OP_RW,    32'h66,        32'd0,         -1, 1'b1, 16'd3, 1'b1);
    vt[11] = mk(OP_WR,    32'd1,         32'd0,         -1, 1'b1, 16'd4, 1'b1);
    vt[12] = mk(OP_LW,    32'd9,         32'd0,         -1, 1'b1, 16'd5, 1'b0);
    vt[13] = mk(OP_WR,    32'hCAFE,      32'd0,          9, 1'b0, 16'd5, 1'b0);
    vt[14] = mk(OP_RW,    32'hBEEF,      32'hCAFE,       9, 1'b0, 16'd5, 1'b0);
    vt[15] = mk(OP_RD,    32'd0,         32'hBEEF,      -1, 1'b0, 16'd5, 1'b0);
    vt[16] = mk(OP_LATCH, 32'd31,        32'd0,         -1, 1'b0, 16'd5, 1'b0);
    vt[17] = mk(OP_WR,    32'h31,        32'd0,         31, 1'b0, 16'd5, 1'b0);
    vt[18] = mk(OP_RD,    32'd0,         32'h31,        -1, 1'b0, 16'd5, 1'b0);
    vt[19] = mk(OP_LATCH, 32'd32,        32'd0,         -1, 1'b0, 16'd5, 1'b1);
    vt[20] = mk(OP_RD,    32'd0,         32'd0,         -1, 1'b1, 16'd6, 1'b1);
    vt[21] = mk(OP_CLRWR, 32'd5,         32'd0,         -1, 1'b1, 16'd0, 1'b1);
    vt[22] = mk(OP_LATCH, 32'd7,         32'd0,         -1, 1'b0, 16'd0, 1'b0);
    vt[23] = mk(OP_RW,    32'h99,        32'h1234,      -1, 1'b1, 16'd1, 1'b0);

    // Reset state, checked while reset is still asserted.
    #9;
    chk_reset_state("por");
    #1;
    reset = 1'b1;

    // Vector table.
    for (int k = 0; k < 24; k++) begin
      v = vt[k];
      case (v.op)
        OP_LATCH: drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v.data);
        OP_WR:    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v.data);
        OP_RD:    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, v.data);
        OP_RW:    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, v.data);
        OP_LW:    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v.data);
        default:  drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, v.data);
      endcase
      if (v.op == OP_RD || v.op == OP_RW) sb_q.push_back(v.exp_tx);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      s1 = '0;
      if (v.exp_wr >= 0) m_write(v.exp_wr, v.data, s1);
      chk($sformatf("v%0d_illegal_access", k), 64'(illegal_access), 64'(v.exp_ia));
      chk($sformatf("v%0d_err_cnt", k), 64'(err_cnt), 64'(v.exp_err));
      chk($sformatf("v%0d_illegal_reg_num", k), 64'(illegal_reg_num), 64'(v.exp_ill));
      chk($sformatf("v%0d_wr_strobe", k), 64'(wr_strobe), 64'(s1));
      chk($sformatf("v%0d_shadow_pending", k), 64'(shadow_pending), 64'(m_pend != 0));
      chk_regs($sformatf("v%0d_reg_out", k));
    end

    // Shadow/commit sequence (commit is a no-op without shadowing).
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd9); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_write(3, 32'd9, s1);
    chk("sh_wr_strobe", 64'(wr_strobe), 64'(s1));
    chk("sh_wr_reg3", 64'(reg_out[3*DW +: DW]), SHADOW ? 64'(0) : 64'(9));
    chk("sh_wr_pending", 64'(shadow_pending), 64'(SHADOW));
    chk_regs("sh_wr_reg_out");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0); sb_q.push_back(32'd9); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_commit(s1);
    chk("cm_wr_strobe", 64'(wr_strobe), 64'(s1));
    chk("cm_reg3", 64'(reg_out[3*DW +: DW]), 64'(9));
    chk("cm_pending", 64'(shadow_pending), 64'(0));
    chk_regs("cm_reg_out");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_write(3, 32'hA, s1);
    chk("wa_wr_strobe", 64'(wr_strobe), 64'(s1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_commit(s1);
    m_write(3, 32'hB, s2);
    chk("wc_wr_strobe", 64'(wr_strobe), 64'(s1 | s2));
    chk("wc_reg3", 64'(reg_out[3*DW +: DW]), SHADOW ? 64'hA : 64'hB);
    chk("wc_pending", 64'(shadow_pending), 64'(SHADOW));
    chk_regs("wc_reg_out");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_commit(s1);
    chk("c2_wr_strobe", 64'(wr_strobe), 64'(s1));
    chk("c2_reg3", 64'(reg_out[3*DW +: DW]), 64'hB);
    chk("c2_pending", 64'(shadow_pending), 64'(0));

    // err_cnt saturation and clear priority.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd40); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); tick();
    chk("sat_clr", 64'(err_cnt), 64'(0));
    for (int k = 0; k < 65535; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      sb_q.push_back(32'd0);
      tick();
    end
    chk("sat_full", 64'(err_cnt), 64'hFFFF);
    chk("sat_ia", 64'(illegal_access), 64'(1));
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      sb_q.push_back(32'd0);
      tick();
    end
    chk("sat_hold", 64'(err_cnt), 64'hFFFF);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0); sb_q.push_back(32'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("sat_clr_prio", 64'(err_cnt), 64'(0));

    // Asynchronous reset in the middle of a write.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0); sb_q.push_back(32'd0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0); sb_q.push_back(32'hDEADBEEF); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4); tick();
    chk("pre_rst_err", 64'(err_cnt), 64'(1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4444);
    #2;
    reset = 1'b0;
    #1;
    m_init();
    chk_reset_state("arst_wr");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #2;
    reset = 1'b1;
    tick();
    chk_regs("arst_wr_after");

    // Asynchronous reset during a commit.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h66); tick();
    m_write(6, 32'h66, s1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    m_init();
    chk_reset_state("arst_cm");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #2;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("arst_cm_strobe", 64'(wr_strobe), 64'(0));
    chk_regs("arst_cm_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
